// File: rtl/clk_div_reconfig_ctrl_if.sv
// Ratio-change request channel for clk_div_reconfig_ctrl.
// The requester (master) drives valid and the requested half-period count.
// The controller (slave) answers with ready.
interface clk_div_reconfig_ctrl_if #(
  parameter int DIV_W = 10
);
  logic             req_valid;
  logic [DIV_W-1:0] req_div;
  logic             req_ready;

  modport master (output req_valid, output req_div, input  req_ready);
  modport slave  (input  req_valid, input  req_div, output req_ready);
endinterface

// File: rtl/clk_div_reconfig_ctrl.sv
// Glitch-free reconfiguration controller for the programmable clock divider.
// A ratio change is sequenced as RUN -> DRAIN -> HOLD -> LOAD -> RUN:
//   - DRAIN finishes the current high phase and then one full low phase.
//   - HOLD keeps the output low for HOLD_CYCLES extra cycles.
//   - LOAD swaps in the new ratio.
// Because of this ordering the output can never produce a runt pulse.
// Optional feature: define CLKDIV_RECONFIG_CNT_EN to add an 8-bit reconfig_cnt
// output. It counts completed ratio loads.
module clk_div_reconfig_ctrl #(
  parameter int DIV_W       = 10,
  parameter int DEFAULT_DIV = 4,
  parameter int MIN_DIV     = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  clk_div_reconfig_ctrl_if.slave req,
  output logic                   div_out,
  output logic                   div_tick,
  output logic [DIV_W-1:0]       cur_div,
  output logic                   busy,
  output logic                   err
`ifdef CLKDIV_RECONFIG_CNT_EN
  ,
  output logic [7:0]             reconfig_cnt
`endif
);

  localparam int               HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0]  MIN_DIV_V  = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0]  DEF_DIV_V  = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    LOAD  = 2'd3
  } state_e;

  state_e            state_q,   state_d;
  logic [DIV_W-1:0]  cnt_q,     cnt_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;
  logic              div_out_q, div_out_d;
  logic              tick_q,    tick_d;
  logic [DIV_W-1:0]  cur_div_q, cur_div_d;
  logic [DIV_W-1:0]  pending_q, pending_d;
  logic              err_q,     err_d;
  logic              terminal;
`ifdef CLKDIV_RECONFIG_CNT_EN
  logic [7:0]        rc_cnt_q,  rc_cnt_d;
`endif

  // Next-state and datapath logic for the divider and the change sequencer.
  // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    div_out_d = div_out_q;
    tick_d    = 1'b0;
    cur_div_d = cur_div_q;
    pending_d = pending_q;
    err_d     = 1'b0;
`ifdef CLKDIV_RECONFIG_CNT_EN
    rc_cnt_d  = rc_cnt_q;
`endif
    terminal  = (cnt_q == (cur_div_q - 1'b1));

    unique case (state_q)
      RUN: begin
        if (terminal) begin
          cnt_d     = '0;
          div_out_d = ~div_out_q;
          tick_d    = ~div_out_q;   // rising edge of div_out
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // A handshake completes on this edge, because ready is high in RUN.
        if (req.req_valid) begin
          if (req.req_div < MIN_DIV_V) begin
            err_d = 1'b1;
          end else if (req.req_div != cur_div_q) begin
            pending_d = req.req_div;
            state_d   = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (terminal) begin
          cnt_d = '0;
          if (div_out_q) begin
            div_out_d = 1'b0;       // finish the high phase normally
          end else begin
            state_d = HOLD;         // a full low phase is done; stop toggling here
            hold_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        div_out_d = 1'b0;
        cnt_d     = '0;
        if (hold_q == HOLD_LAST) begin
          state_d = LOAD;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      LOAD: begin
        cur_div_d = pending_q;
        cnt_d     = '0;
        div_out_d = 1'b0;
        state_d   = RUN;
`ifdef CLKDIV_RECONFIG_CNT_EN
        rc_cnt_d  = rc_cnt_q + 8'd1; // wraps 255 -> 0
`endif
      end
    endcase
  end

  // State and datapath registers; reset discards any pending change.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      hold_q    <= '0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
      cur_div_q <= DEF_DIV_V;
      pending_q <= DEF_DIV_V;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
      cur_div_q <= cur_div_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

`ifdef CLKDIV_RECONFIG_CNT_EN
  // Count of completed ratio loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rc_cnt_q <= 8'd0;
    end else begin
      rc_cnt_q <= rc_cnt_d;
    end
  end

  assign reconfig_cnt = rc_cnt_q;
`endif

  assign req.req_ready = (state_q == RUN);
  assign busy          = (state_q != RUN);
  assign div_out       = div_out_q;
  assign div_tick      = tick_q;
  assign cur_div       = cur_div_q;
  assign err           = err_q;

endmodule

// File: tb/tb_clk_div_reconfig_ctrl.sv
// Directed bench for clk_div_reconfig_ctrl (DEFAULT_DIV=4, MIN_DIV=2, HOLD_CYCLES=4).
// Cycle k counts the clock edges since reset release; cycle 0 is the reset state.
module tb_clk_div_reconfig_ctrl;

  localparam int DIV_W = 10;

  logic clk;
  logic reset_n;
  logic div_out;
  logic div_tick;
  logic [DIV_W-1:0] cur_div;
  logic busy;
  logic err;
`ifdef CLKDIV_RECONFIG_CNT_EN
  logic [7:0] reconfig_cnt;
`endif

  clk_div_reconfig_ctrl_if #(.DIV_W(DIV_W)) req_if ();

  clk_div_reconfig_ctrl #(
    .DIV_W(DIV_W), .DEFAULT_DIV(4), .MIN_DIV(2), .HOLD_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req_if),
    .div_out  (div_out),
    .div_tick (div_tick),
    .cur_div  (cur_div),
    .busy     (busy),
    .err      (err)
`ifdef CLKDIV_RECONFIG_CNT_EN
    ,
    .reconfig_cnt (reconfig_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  typedef struct {
    string            name;
    logic [DIV_W-1:0] div;
    logic             exp_err;
    logic             exp_busy;
    logic [DIV_W-1:0] exp_cur;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at k=%0d", name, k);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    k = 0;
  endtask

  function automatic logic exp_div4(input int cyc);
    return logic'((cyc / 4) % 2);
  endfunction

  initial begin
    vecs[0] = '{name: "rej0",  div: 10'd0, exp_err: 1'b1, exp_busy: 1'b0, exp_cur: 10'd4};
    vecs[1] = '{name: "rej1",  div: 10'd1, exp_err: 1'b1, exp_busy: 1'b0, exp_cur: 10'd4};
    vecs[2] = '{name: "noop4", div: 10'd4, exp_err: 1'b0, exp_busy: 1'b0, exp_cur: 10'd4};
    vecs[3] = '{name: "rej1b", div: 10'd1, exp_err: 1'b1, exp_busy: 1'b0, exp_cur: 10'd4};

    reset_n          = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_div   = '0;
    apply_reset();

    // Reset state and the free-running divider at DEFAULT_DIV=4.
    check("rst_ready",   req_if.req_ready, 1);
    check("rst_busy",    busy,    0);
    check("rst_err",     err,     0);
    check("rst_cur_div", cur_div, 4);
`ifdef CLKDIV_RECONFIG_CNT_EN
    check("rst_rcnt", reconfig_cnt, 0);
`endif
    for (int c = 0; c <= 20; c++) begin
      check("wave_div_out", div_out, exp_div4(k));
      check("wave_tick", div_tick, (k > 0 && (k % 8) == 4) ? 1 : 0);
      step();
    end

    // Rejected and no-op requests leave the waveform and the ratio untouched.
    for (int v = 0; v < 4; v++) begin
      req_if.req_valid = 1'b1;
      req_if.req_div   = vecs[v].div;
      step();
      req_if.req_valid = 1'b0;
      check({vecs[v].name, "_err"},     err,     vecs[v].exp_err);
      check({vecs[v].name, "_busy"},    busy,    vecs[v].exp_busy);
      check({vecs[v].name, "_cur"},     cur_div, vecs[v].exp_cur);
      check({vecs[v].name, "_div_out"}, div_out, exp_div4(k));
      step();
      check({vecs[v].name, "_err_end"}, err,     0);
      check({vecs[v].name, "_wave2"},   div_out, exp_div4(k));
    end

    // Back-to-back rejects give back-to-back err pulses.
    req_if.req_valid = 1'b1;
    req_if.req_div   = 10'd1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("b2b_err", err, 1);
    end
    req_if.req_valid = 1'b0;
    step();
    check("b2b_err_end", err, 0);
    check("b2b_wave", div_out, exp_div4(k));

    // Change 4 -> 6, issued while div_out is high with cnt=1.
    while ((k % 8) != 5) step();
    check("chg_start_high", div_out, 1);
    req_if.req_valid = 1'b1;
    req_if.req_div   = 10'd6;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (j == 1) req_if.req_valid = 1'b0;
      check("chg_div_out", div_out,
            (j < 3) ? 1 : (j < 18) ? 0 : (((j - 18) / 6) % 2 == 0) ? 1 : 0);
      check("chg_tick", div_tick, (j == 18 || j == 30) ? 1 : 0);
      check("chg_busy", busy, (j <= 11) ? 1 : 0);
      check("chg_cur_div", cur_div, (j < 12) ? 4 : 6);
    end

    // A held request is accepted on the first RUN cycle after LOAD.
    apply_reset();
    req_if.req_valid = 1'b1;
    req_if.req_div   = 10'd6;
    step();
    check("held_busy1", busy, 1);
    req_if.req_div = 10'd8;
    begin : w1
      for (int n = 0; n < 60; n++) begin
        if (!busy) disable w1;
        step();
      end
      timeout("held_wait1");
    end
    check("held_cur6",  cur_div, 6);
    check("held_ready", req_if.req_ready, 1);
    step();
    req_if.req_valid = 1'b0;
    check("held_busy2", busy, 1);
    check("held_cur6b", cur_div, 6);
    begin : w2
      for (int n = 0; n < 60; n++) begin
        if (!busy) disable w2;
        step();
      end
      timeout("held_wait2");
    end
    check("held_cur8", cur_div, 8);
`ifdef CLKDIV_RECONFIG_CNT_EN
    check("held_rcnt", reconfig_cnt, 2);
`endif

    // Change 8 -> 4 aborted by reset during HOLD.
    begin : w3
      for (int n = 0; n < 40; n++) begin
        if (div_tick) disable w3;
        step();
      end
      timeout("tick_wait");
    end
    req_if.req_valid = 1'b1;
    req_if.req_div   = 10'd4;
    for (int j = 1; j <= 17; j++) begin
      step();
      if (j == 1) req_if.req_valid = 1'b0;
      check("abort_div_out", div_out, (j < 8) ? 1 : 0);
      check("abort_busy", busy, 1);
    end
    #2 reset_n = 1'b0;
    #1;
    check("async_busy",    busy,    0);
    check("async_ready",   req_if.req_ready, 1);
    check("async_cur_div", cur_div, 4);
    check("async_div_out", div_out, 0);
    check("async_tick",    div_tick, 0);
    check("async_err",     err,     0);
`ifdef CLKDIV_RECONFIG_CNT_EN
    check("async_rcnt", reconfig_cnt, 0);
`endif
    apply_reset();
    for (int c = 0; c <= 20; c++) begin
      check("post_div_out", div_out, exp_div4(k));
      check("post_busy",    busy,    0);
      check("post_cur_div", cur_div, 4);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
